// File: rtl/sequence_generator.sv
// Master phase sequencer: 16-state Johnson counter with a parallel binary phase index,
// a cycle-start strobe, a synchronous load port and self-recovery from illegal patterns.
module sequence_generator #(
    parameter logic [7:0] RESET_S = 8'h00
) (
    input  logic       CLK_n,
    input  logic       RESET_n,
    input  logic       HOLD,
    input  logic       LOAD,
    input  logic [7:0] LOAD_VAL,
    input  logic       ERR_CLR,
    output logic [7:0] S,
    output logic [3:0] PHASE,
    output logic       CYCLE_START,
    output logic       LOCK_ERR
);

    function automatic logic is_legal(input logic [7:0] v);
        case (v)
            8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
            8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80: is_legal = 1'b1;
            default: is_legal = 1'b0;
        endcase
    endfunction

    // Illegal values map to 0, which is also the phase forced on an illegal load.
    function automatic logic [3:0] index_of(input logic [7:0] v);
        case (v)
            8'h01:   index_of = 4'd1;
            8'h03:   index_of = 4'd2;
            8'h07:   index_of = 4'd3;
            8'h0F:   index_of = 4'd4;
            8'h1F:   index_of = 4'd5;
            8'h3F:   index_of = 4'd6;
            8'h7F:   index_of = 4'd7;
            8'hFF:   index_of = 4'd8;
            8'hFE:   index_of = 4'd9;
            8'hFC:   index_of = 4'd10;
            8'hF8:   index_of = 4'd11;
            8'hF0:   index_of = 4'd12;
            8'hE0:   index_of = 4'd13;
            8'hC0:   index_of = 4'd14;
            8'h80:   index_of = 4'd15;
            default: index_of = 4'd0;
        endcase
    endfunction

    localparam logic [3:0] RESET_PHASE = index_of(RESET_S);

    logic [7:0] s_next;
    logic [3:0] phase_next;
    logic       cycle_start_next;
    logic       err_set;
    logic       lock_err_next;

    // Priority: load, then recovery (ignores HOLD), then hold, then advance.
    always_comb begin
        s_next           = S;
        phase_next       = PHASE;
        cycle_start_next = 1'b0;
        err_set          = 1'b0;
        if (LOAD) begin
            s_next     = LOAD_VAL;
            phase_next = index_of(LOAD_VAL);
        end else if (!is_legal(S)) begin
            s_next           = 8'h00;
            phase_next       = 4'd0;
            err_set          = 1'b1;
            cycle_start_next = 1'b1;
        end else if (!HOLD) begin
            s_next           = {S[6:0], ~S[7]};
            phase_next       = PHASE + 4'd1;
            cycle_start_next = (S == 8'h80);
        end
    end

    always_comb begin
        lock_err_next = LOCK_ERR;
        if (err_set) begin
            lock_err_next = 1'b1;
        end else if (ERR_CLR) begin
            lock_err_next = 1'b0;
        end
    end

    always_ff @(posedge CLK_n or negedge RESET_n) begin
        if (!RESET_n) begin
            S           <= RESET_S;
            PHASE       <= RESET_PHASE;
            CYCLE_START <= 1'b0;
            LOCK_ERR    <= 1'b0;
        end else begin
            S           <= s_next;
            PHASE       <= phase_next;
            CYCLE_START <= cycle_start_next;
            LOCK_ERR    <= lock_err_next;
        end
    end

endmodule
